id_ex_ctrl_buffer: RTL

- Consumer end of the control-unit decode interface. Captures one decoded instruction per cycle: the control bundle, the raw 32-bit instruction and the next PC.
- Holds it in a 2-entry skid buffer between decode (ID) and execute (EX), with valid/ready handshakes on both sides.
- Handles pipeline flush and halt sequencing, and drives the bubble-safe control fields into EX.

---
 rtl/cpu_types_pkg.sv | 42 ++++
 rtl/id_ex_ctrl_buffer_if.sv | 60 ++++++
 rtl/id_ex_ctrl_buffer_perf_ctr.sv | 19 +
 rtl/id_ex_ctrl_buffer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the decode -> execute boundary: ALU op encoding,
// the ID/EX control bundle, buffer depth and the ID/EX buffer state names.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } aluop_t;

  typedef struct packed {
    logic [2:0] jump_t;
    logic [1:0] RegDest;
    logic       RegWen;
    logic [2:0] ALUsrc;
    aluop_t     alu_op;
    logic       mem2reg;
    logic       pc2reg;
    logic       MemWrite;
    logic       careOF;
    logic       halt;
    logic       atomic;
  } id_ex_ctrl_t;

  localparam int ID_EX_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ONE    = 2'd1,
    FULL   = 2'd2,
    HALTED = 2'd3
  } id_ex_state_t;

endpackage

// File: rtl/id_ex_ctrl_buffer_if.sv
// ID -> EX handshake bundle. master = decode/execute side (testbench),
// slave = the id_ex_ctrl_buffer itself.
interface id_ex_ctrl_buffer_if #(
  parameter int PCW = 32
);
  import cpu_types_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [31:0]    in_instr;
  logic [PCW-1:0] in_npc;
  logic [2:0]     in_jump_t;
  logic [1:0]     in_RegDest;
  logic           in_RegWen;
  logic [2:0]     in_ALUsrc;
  aluop_t         in_alu_op;
  logic           in_mem2reg;
  logic           in_pc2reg;
  logic           in_MemWrite;
  logic           in_careOF;
  logic           in_halt;
  logic           in_atomic;
  logic           flush;

  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_instr;
  logic [PCW-1:0] out_npc;
  logic [2:0]     out_jump_t;
  logic [1:0]     out_RegDest;
  logic           out_RegWen;
  logic [2:0]     out_ALUsrc;
  aluop_t         out_alu_op;
  logic           out_mem2reg;
  logic           out_pc2reg;
  logic           out_MemWrite;
  logic           out_careOF;
  logic           out_halt;
  logic           out_atomic;
  logic           halted;

  modport master (
    output in_valid, in_instr, in_npc, in_jump_t, in_RegDest, in_RegWen,
           in_ALUsrc, in_alu_op, in_mem2reg, in_pc2reg, in_MemWrite,
           in_careOF, in_halt, in_atomic, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_npc, out_jump_t, out_RegDest,
           out_RegWen, out_ALUsrc, out_alu_op, out_mem2reg, out_pc2reg,
           out_MemWrite, out_careOF, out_halt, out_atomic, halted
  );

  modport slave (
    input  in_valid, in_instr, in_npc, in_jump_t, in_RegDest, in_RegWen,
           in_ALUsrc, in_alu_op, in_mem2reg, in_pc2reg, in_MemWrite,
           in_careOF, in_halt, in_atomic, flush, out_ready,
    output in_ready, out_valid, out_instr, out_npc, out_jump_t, out_RegDest,
           out_RegWen, out_ALUsrc, out_alu_op, out_mem2reg, out_pc2reg,
           out_MemWrite, out_careOF, out_halt, out_atomic, halted
  );

endinterface

// File: rtl/id_ex_ctrl_buffer_perf_ctr.sv
// id_ex_perf_ctr: 32-bit event counter that sticks at all-ones instead of
// wrapping, so a long stall never reads back as a small number.
module id_ex_perf_ctr (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        inc,
  output logic [31:0] count
);

  // Count qualifying cycles, holding at the maximum value.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/id_ex_ctrl_buffer.sv
// id_ex_ctrl_buffer: 1- or 2-entry skid buffer between decode and execute.
// Output fields are forced to zero on bubbles so EX never sees a stray
// write enable, store, halt or atomic. Halt sequencing: a pushed halt
// blocks younger instructions, a popped halt latches the terminal HALTED
// state. Optional build macro ID_EX_PERF_EN adds stall_cnt / bubble_cnt.
module id_ex_ctrl_buffer
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = ID_EX_DEPTH,
  parameter int PCW   = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  id_ex_ctrl_buffer_if.slave  bus
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         bubble_cnt
`endif
);

  typedef struct packed {
    logic [31:0]    instr;
    logic [PCW-1:0] npc;
    id_ex_ctrl_t    ctrl;
  } entry_t;

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  // Storage is always two slots; DEPTH=1 simply never touches slot 1.
  entry_t       mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   count_q, count_nxt;
  logic         halt_pending_q, halt_pending_nxt;
  logic         halted_nxt;
  logic         in_ready_q, in_ready_nxt;
  id_ex_state_t state_q, state_nxt;

  entry_t entry_in, head, head_masked;
  logic   out_valid, push, pop;

  function automatic logic adv(input logic p);
    return (DEPTH == 1) ? 1'b0 : ~p;
  endfunction

  assign out_valid = (count_q != 2'd0);
  assign push      = bus.in_valid & in_ready_q & ~bus.flush;
  assign pop       = out_valid & bus.out_ready;
  assign head      = mem[rd_ptr];

  // Pack the incoming decode fields into one storage entry.
  always_comb begin
    entry_in               = '0;
    entry_in.instr         = bus.in_instr;
    entry_in.npc           = bus.in_npc;
    entry_in.ctrl.jump_t   = bus.in_jump_t;
    entry_in.ctrl.RegDest  = bus.in_RegDest;
    entry_in.ctrl.RegWen   = bus.in_RegWen;
    entry_in.ctrl.ALUsrc   = bus.in_ALUsrc;
    entry_in.ctrl.alu_op   = bus.in_alu_op;
    entry_in.ctrl.mem2reg  = bus.in_mem2reg;
    entry_in.ctrl.pc2reg   = bus.in_pc2reg;
    entry_in.ctrl.MemWrite = bus.in_MemWrite;
    entry_in.ctrl.careOF   = bus.in_careOF;
    entry_in.ctrl.halt     = bus.in_halt;
    entry_in.ctrl.atomic   = bus.in_atomic;
  end

  // Next-state for occupancy, halt tracking and the registered ready.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    count_nxt = count_q;
    unique case ({push, pop})
      2'b10:   count_nxt = count_q + 2'd1;
      2'b01:   count_nxt = count_q - 2'd1;
      default: count_nxt = count_q;
    endcase
    if (bus.flush) count_nxt = 2'd0;

    halt_pending_nxt = bus.flush ? 1'b0 : (halt_pending_q | (push & bus.in_halt));
    halted_nxt       = (state_q == HALTED) | (pop & head.ctrl.halt);
    in_ready_nxt     = (count_nxt < DEPTH_C) & ~halt_pending_nxt & ~halted_nxt;

    state_nxt = EMPTY;
    if (halted_nxt) begin
      state_nxt = HALTED;
    end else begin
      unique case (count_nxt)
        2'd0:    state_nxt = EMPTY;
        2'd1:    state_nxt = ONE;
        default: state_nxt = FULL;
      endcase
    end
  end

  // Control state: occupancy, pointers, halt tracking, FSM, ready.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!nRST) begin
      count_q        <= 2'd0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      halt_pending_q <= 1'b0;
      in_ready_q     <= 1'b0;
      state_q        <= EMPTY;
    end else begin
      count_q        <= count_nxt;
      halt_pending_q <= halt_pending_nxt;
      in_ready_q     <= in_ready_nxt;
      state_q        <= state_nxt;
      if (bus.flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= adv(wr_ptr);
        if (pop)  rd_ptr <= adv(rd_ptr);
      end
    end
  end

  // Entry storage written on push.
  always_ff @(posedge CLK) begin
    // NOTE: payload storage is left unreset; an entry is only visible while count says it is valid, and bubbles are masked.
    if (push) mem[wr_ptr] <= entry_in;
  end

  assign head_masked = out_valid ? head : '0;

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid;
  assign bus.out_instr    = head_masked.instr;
  assign bus.out_npc      = head_masked.npc;
  assign bus.out_jump_t   = head_masked.ctrl.jump_t;
  assign bus.out_RegDest  = head_masked.ctrl.RegDest;
  assign bus.out_RegWen   = head_masked.ctrl.RegWen;
  assign bus.out_ALUsrc   = head_masked.ctrl.ALUsrc;
  assign bus.out_alu_op   = head_masked.ctrl.alu_op;
  assign bus.out_mem2reg  = head_masked.ctrl.mem2reg;
  assign bus.out_pc2reg   = head_masked.ctrl.pc2reg;
  assign bus.out_MemWrite = head_masked.ctrl.MemWrite;
  assign bus.out_careOF   = head_masked.ctrl.careOF;
  assign bus.out_halt     = head_masked.ctrl.halt;
  assign bus.out_atomic   = head_masked.ctrl.atomic;
  assign bus.halted       = (state_q == HALTED);

`ifdef ID_EX_PERF_EN
  id_ex_perf_ctr u_stall_ctr (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (out_valid & ~bus.out_ready),
    .count (stall_cnt)
  );

  id_ex_perf_ctr u_bubble_ctr (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (~out_valid & (state_q != HALTED)),
    .count (bubble_cnt)
  );
`endif

endmodule
